aes64_iter_encrypt: RTL and testbench

- Iterative, clocked 64-bit AES-style encryptor. Replaces the fully unrolled combinational 8-round datapath with one shared round datapath reused once per clock.
- Instantiates the existing SubBytes, ShiftRows, mix_coloumns and AddRoundKey blocks exactly once each.
- Adds three things the unrolled version lacks: a parametrised round count, an optional per-round key rotation, and valid/ready handshakes on both sides.
- Sits between the host input register slice and the ciphertext output FIFO.

---
 rtl/aes64_iter_encrypt.sv | 195 +++++++++++++++++++
 tb/tb_aes64_iter_encrypt.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes64_iter_encrypt.sv
// aes64_iter_encrypt: iterative 64-bit AES-style encryptor that reuses one round datapath per clock.
// The state is 8 bytes with byte 0 in [63:56], laid out column-major as 4 rows x 2 columns.

module SubBytes (
    input  logic [63:0] state_in,
    output logic [63:0] state_out
);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        state_out = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            state_out[i*8 +: 8] = SBOX[state_in[i*8 +: 8]];
        end
    end
endmodule

module ShiftRows (
    input  logic [63:0] state_in,
    output logic [63:0] state_out
);
    // Two columns only: rows 1 and 3 swap columns, rows 0 and 2 stay put.
    always_comb begin
        state_out = {state_in[63:56], state_in[23:16], state_in[47:40], state_in[7:0],
                     state_in[31:24], state_in[55:48], state_in[15:8],  state_in[39:32]};
    end
endmodule

module mix_coloumns (
    input  logic [63:0] state_in,
    output logic [63:0] state_out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    always_comb begin
        state_out = {mix_col(state_in[63:32]), mix_col(state_in[31:0])};
    end
endmodule

module AddRoundKey (
    input  logic [63:0] state_in,
    input  logic [63:0] round_key,
    output logic [63:0] state_out
);
    always_comb begin
        state_out = state_in ^ round_key;
    end
endmodule

module aes64_iter_encrypt #(
    parameter int unsigned NUM_ROUNDS = 8,
    parameter int unsigned ROT_BYTES  = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      plaintext,
    input  logic [63:0]      key,
    input  logic             key_rot_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      ciphertext,
    output logic             busy,
    output logic [CNT_W-1:0] round_idx
);
    // Out-of-range rotations (e.g. 8 bytes) fold to a whole-word rotate, i.e. no rotation.
    localparam int unsigned      ROT_BITS  = (8 * ROT_BYTES) % 64;
    localparam logic [CNT_W-1:0] LAST_RND  = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] FIRST_RND = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [63:0]        state_reg_q, state_reg_d;
    logic [63:0]        key_reg_q, key_reg_d;
    logic               rot_reg_q, rot_reg_d;
    logic [CNT_W-1:0]   round_idx_q, round_idx_d;
    logic [63:0]        ciphertext_q, ciphertext_d;

    logic [63:0]        key_rotated, round_key;
    logic [63:0]        sb_out, sr_out, mc_out, round_state, ark_out;
    logic               last_round;

    always_comb begin
        key_rotated = (key_reg_q << ROT_BITS) | (key_reg_q >> ((64 - ROT_BITS) % 64));
        round_key   = rot_reg_q ? key_rotated : key_reg_q;
        last_round  = (round_idx_q == LAST_RND);
        round_state = last_round ? sr_out : mc_out;
    end

    SubBytes     u_sub_bytes  (.state_in(state_reg_q), .state_out(sb_out));
    ShiftRows    u_shift_rows (.state_in(sb_out),      .state_out(sr_out));
    mix_coloumns u_mix_cols   (.state_in(sr_out),      .state_out(mc_out));
    AddRoundKey  u_add_rk     (.state_in(round_state), .round_key(round_key), .state_out(ark_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            state_reg_q  <= '0;
            key_reg_q    <= '0;
            rot_reg_q    <= 1'b0;
            round_idx_q  <= '0;
            ciphertext_q <= '0;
        end else begin
            state_q      <= state_d;
            state_reg_q  <= state_reg_d;
            key_reg_q    <= key_reg_d;
            rot_reg_q    <= rot_reg_d;
            round_idx_q  <= round_idx_d;
            ciphertext_q <= ciphertext_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_round) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state_reg_d  = state_reg_q;
        key_reg_d    = key_reg_q;
        rot_reg_d    = rot_reg_q;
        round_idx_d  = round_idx_q;
        ciphertext_d = ciphertext_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_reg_d = plaintext ^ key;
                    key_reg_d   = key;
                    rot_reg_d   = key_rot_en;
                    round_idx_d = FIRST_RND;
                end
            end
            BUSY: begin
                state_reg_d = ark_out;
                key_reg_d   = round_key;
                if (last_round) begin
                    ciphertext_d = ark_out;
                    round_idx_d  = '0;
                end else begin
                    round_idx_d  = round_idx_q + FIRST_RND;
                end
            end
            DONE: ;
            default: round_idx_d = '0;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
        ciphertext = ciphertext_q;
        round_idx  = round_idx_q;
    end
endmodule

// File: tb/tb_aes64_iter_encrypt.sv
// Bench for aes64_iter_encrypt: four builds (8/ROT1, 8/ROT2, 1 round, 15 rounds) checked against
// a reference model whose S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_aes64_iter_encrypt;
    localparam int unsigned NR0 = 8,  RB0 = 1;
    localparam int unsigned NR1 = 8,  RB1 = 2;
    localparam int unsigned NR2 = 1,  RB2 = 1;
    localparam int unsigned NR3 = 15, RB3 = 1;

    int unsigned nr_of [4] = '{NR0, NR1, NR2, NR3};
    int unsigned rb_of [4] = '{RB0, RB1, RB2, RB3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  iv = '0;
    logic        out_ready = 1'b0;
    logic [63:0] pt = '0;
    logic [63:0] ky = '0;
    logic        kre = 1'b0;
    logic [3:0]  ir, ov, bz;
    logic [63:0] ct [4];
    logic [3:0]  ri [4];

    logic [63:0] exp_q [$];
    logic [7:0]  sbox_t [256];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes64_iter_encrypt #(.NUM_ROUNDS(NR0), .ROT_BYTES(RB0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .plaintext(pt), .key(ky),
        .key_rot_en(kre), .out_valid(ov[0]), .out_ready(out_ready), .ciphertext(ct[0]),
        .busy(bz[0]), .round_idx(ri[0]));
    aes64_iter_encrypt #(.NUM_ROUNDS(NR1), .ROT_BYTES(RB1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .plaintext(pt), .key(ky),
        .key_rot_en(kre), .out_valid(ov[1]), .out_ready(out_ready), .ciphertext(ct[1]),
        .busy(bz[1]), .round_idx(ri[1]));
    aes64_iter_encrypt #(.NUM_ROUNDS(NR2), .ROT_BYTES(RB2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .plaintext(pt), .key(ky),
        .key_rot_en(kre), .out_valid(ov[2]), .out_ready(out_ready), .ciphertext(ct[2]),
        .busy(bz[2]), .round_idx(ri[2]));
    aes64_iter_encrypt #(.NUM_ROUNDS(NR3), .ROT_BYTES(RB3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .plaintext(pt), .key(ky),
        .key_rot_en(kre), .out_valid(ov[3]), .out_ready(out_ready), .ciphertext(ct[3]),
        .busy(bz[3]), .round_idx(ri[3]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = '0;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
        int unsigned m;
        m = n % 64;
        if (m == 0) return x;
        return (x << m) | (x >> (64 - m));
    endfunction

    function automatic logic [63:0] model(input logic [63:0] p, input logic [63:0] k,
                                          input logic rot, input int unsigned rb, input int unsigned nr);
        logic [63:0] s, kk;
        logic [7:0]  b [8];
        logic [7:0]  sr [8];
        logic [7:0]  m [8];
        s = p ^ k;
        kk = k;
        for (int r = 1; r <= int'(nr); r++) begin
            if (rot) kk = rotl64(kk, 8 * rb);
            for (int i = 0; i < 8; i++) b[i] = sbox_t[s[63-8*i -: 8]];
            for (int c = 0; c < 2; c++)
                for (int w = 0; w < 4; w++) sr[4*c+w] = b[4*((c+w)%2)+w];
            for (int i = 0; i < 8; i++) m[i] = sr[i];
            if (r < int'(nr)) begin
                for (int c = 0; c < 2; c++)
                    for (int w = 0; w < 4; w++)
                        m[4*c+w] = gmul(8'h02, sr[4*c+w]) ^ gmul(8'h03, sr[4*c+(w+1)%4])
                                 ^ sr[4*c+(w+2)%4] ^ sr[4*c+(w+3)%4];
            end
            for (int i = 0; i < 8; i++) s[63-8*i -: 8] = m[i];
            s = s ^ kk;
        end
        return s;
    endfunction

    task automatic start_job(input int inst, input logic [63:0] p, input logic [63:0] k,
                             input logic rot, input bit push);
        pt = p; ky = k; kre = rot; iv[inst] = 1'b1;
        @(negedge clk);
        iv[inst] = 1'b0;
        if (push) exp_q.push_back(model(p, k, rot, rb_of[inst], nr_of[inst]));
    endtask

    task automatic wait_done(input int inst, input int maxc, output int lat);
        lat = 0;
        while (!ov[inst] && lat < maxc) begin
            @(negedge clk);
            lat++;
        end
        if (!ov[inst]) lat = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (ir[i] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready inst%0d got %b want 1", i, ir[i]); end
            n_vec++; if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid inst%0d got %b want 0", i, ov[i]); end
            n_vec++; if (bz[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy inst%0d got %b want 0", i, bz[i]); end
            n_vec++; if (ct[i] !== 64'h0) begin n_bad++; $display("FAIL reset_ct inst%0d got %h want 0", i, ct[i]); end
            n_vec++; if (ri[i] !== 4'd0) begin n_bad++; $display("FAIL reset_round_idx inst%0d got %0d want 0", i, ri[i]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_golden();
        logic [63:0] gp [3];
        logic [63:0] gk [3];
        logic [63:0] e;
        int lat;
        gp = '{64'h0123456789ABCDEF, 64'h0, '1};
        gk = '{64'h0F1571C947D9E859, 64'h0, '1};
        for (int v = 0; v < 3; v++) begin
            start_job(0, gp[v], gk[v], 1'b0, 1'b1);
            wait_done(0, 30, lat);
            n_vec++; if (lat !== int'(NR0)) begin n_bad++; $display("FAIL golden_latency v%0d got %0d want %0d", v, lat, NR0); end
            e = pop_exp();
            n_vec++; if (ct[0] !== e) begin n_bad++; $display("FAIL golden_ct v%0d got %h want %h", v, ct[0], e); end
            drain();
            n_vec++; if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL golden_idle v%0d in_ready got %b want 1", v, ir[0]); end
        end
    endtask

    task automatic test_key_rotation();
        logic [63:0] e, r0;
        int lat;
        start_job(0, 64'h0123456789ABCDEF, 64'h0F1571C947D9E859, 1'b1, 1'b1);
        wait_done(0, 30, lat);
        e = pop_exp();
        r0 = model(64'h0123456789ABCDEF, 64'h0F1571C947D9E859, 1'b0, RB0, NR0);
        n_vec++; if (ct[0] !== e) begin n_bad++; $display("FAIL rot1_ct got %h want %h", ct[0], e); end
        n_vec++; if (ct[0] === r0) begin n_bad++; $display("FAIL rot1_differs got %h want anything but %h", ct[0], r0); end
        drain();
        start_job(1, 64'h0123456789ABCDEF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b1);
        wait_done(1, 30, lat);
        n_vec++; if (lat !== int'(NR1)) begin n_bad++; $display("FAIL rot2_latency got %0d want %0d", lat, NR1); end
        e = pop_exp();
        r0 = model(64'h0123456789ABCDEF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, RB1, NR1);
        n_vec++; if (ct[1] !== e) begin n_bad++; $display("FAIL rot2_ct got %h want %h", ct[1], e); end
        n_vec++; if (ct[1] !== r0) begin n_bad++; $display("FAIL rot2_invariant got %h want %h", ct[1], r0); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        int lat;
        start_job(0, 64'hDEADBEEF01234567, 64'h1122334455667788, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            iv[0] = 1'b1; pt = 64'h5555_0000_5555_0000 + 64'(c); ky = 64'h0;
            n_vec++; if (ir[0] !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready c%0d got %b want 0", c, ir[0]); end
            n_vec++; if (bz[0] !== 1'b1) begin n_bad++; $display("FAIL busy_flag c%0d got %b want 1", c, bz[0]); end
            @(negedge clk);
        end
        iv[0] = 1'b0;
        wait_done(0, 30, lat);
        if (lat >= 0) lat = lat + 3;
        n_vec++; if (lat !== int'(NR0)) begin n_bad++; $display("FAIL bp_latency got %0d want %0d", lat, NR0); end
        e = pop_exp();
        for (int c = 0; c < 5; c++) begin
            iv[0] = 1'b1; pt = 64'h9999_8888_7777_6666 ^ 64'(c); ky = 64'hFFFF;
            n_vec++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid c%0d got %b want 1", c, ov[0]); end
            n_vec++; if (ct[0] !== e) begin n_bad++; $display("FAIL bp_ct c%0d got %h want %h", c, ct[0], e); end
            n_vec++; if (ir[0] !== 1'b0) begin n_bad++; $display("FAIL done_in_ready c%0d got %b want 0", c, ir[0]); end
            @(negedge clk);
        end
        iv[0] = 1'b0;
        drain();
        n_vec++; if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL bp_release_busy got %b want 0", bz[0]); end
        n_vec++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got %b want 0", ov[0]); end
        n_vec++; if (ct[0] !== e) begin n_bad++; $display("FAIL bp_ct_hold got %h want %h", ct[0], e); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ap [2];
        logic [63:0] ak [2];
        logic [63:0] e;
        int acc_cyc [2];
        int n_acc, n_out;
        bit prev_ov;
        ap = '{64'hCAFEF00D12345678, 64'h0F0E0D0C0B0A0908};
        ak = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
        acc_cyc = '{0, 0};
        n_acc = 0; n_out = 0; prev_ov = 1'b0;
        out_ready = 1'b1; pt = ap[0]; ky = ak[0]; kre = 1'b0; iv[0] = 1'b1;
        for (int cyc = 0; cyc < 40 && n_out < 2; cyc++) begin
            if (ov[0]) begin
                e = pop_exp();
                n_vec++; if (ct[0] !== e) begin n_bad++; $display("FAIL b2b_ct job%0d got %h want %h", n_out, ct[0], e); end
                n_vec++; if (prev_ov) begin n_bad++; $display("FAIL b2b_pulse job%0d out_valid high 2 cycles want 1", n_out); end
                n_out++;
            end
            prev_ov = ov[0];
            if (ir[0] && iv[0] && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                exp_q.push_back(model(pt, ky, 1'b0, RB0, NR0));
                n_acc++;
            end
            @(negedge clk);
            if (n_acc == 1) begin pt = ap[1]; ky = ak[1]; end
            if (n_acc == 2) iv[0] = 1'b0;
        end
        iv[0] = 1'b0; out_ready = 1'b0;
        n_vec++; if (n_out !== 2) begin n_bad++; $display("FAIL b2b_outputs got %0d want 2", n_out); end
        n_vec++; if (acc_cyc[1] - acc_cyc[0] !== int'(NR0) + 2) begin
            n_bad++; $display("FAIL b2b_interval got %0d want %0d", acc_cyc[1] - acc_cyc[0], NR0 + 2);
        end
        exp_q.delete();
    endtask

    task automatic test_rounds1();
        logic [63:0] e;
        int lat;
        start_job(2, 64'h0123456789ABCDEF, 64'h0F1571C947D9E859, 1'b0, 1'b1);
        wait_done(2, 10, lat);
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL n1_latency got %0d want 1", lat); end
        e = pop_exp();
        n_vec++; if (ct[2] !== e) begin n_bad++; $display("FAIL n1_ct got %h want %h", ct[2], e); end
        drain();
    endtask

    task automatic test_rounds15();
        logic [63:0] e;
        start_job(3, 64'h1357_9BDF_0246_8ACE, 64'h0F1571C947D9E859, 1'b1, 1'b1);
        for (int k = 0; k < 15; k++) begin
            n_vec++; if (ri[3] !== 4'(k + 1)) begin n_bad++; $display("FAIL n15_round_idx step%0d got %0d want %0d", k, ri[3], k + 1); end
            n_vec++; if (ov[3] !== 1'b0) begin n_bad++; $display("FAIL n15_early_valid step%0d got %b want 0", k, ov[3]); end
            @(negedge clk);
        end
        e = pop_exp();
        n_vec++; if (ov[3] !== 1'b1) begin n_bad++; $display("FAIL n15_latency out_valid got %b want 1", ov[3]); end
        n_vec++; if (ri[3] !== 4'd0) begin n_bad++; $display("FAIL n15_round_idx_done got %0d want 0", ri[3]); end
        n_vec++; if (ct[3] !== e) begin n_bad++; $display("FAIL n15_ct got %h want %h", ct[3], e); end
        drain();
    endtask

    task automatic test_reset_midjob();
        logic [63:0] e;
        int lat;
        bit seen;
        start_job(0, 64'hA5A5A5A5A5A5A5A5, 64'h3C3C3C3C3C3C3C3C, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_vec++; if (ri[0] !== 4'd4) begin n_bad++; $display("FAIL midrst_pre_round got %0d want 4", ri[0]); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bz[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", bz[0]); end
        n_vec++; if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %b want 1", ir[0]); end
        n_vec++; if (ri[0] !== 4'd0) begin n_bad++; $display("FAIL midrst_round_idx got %0d want 0", ri[0]); end
        n_vec++; if (ct[0] !== 64'h0) begin n_bad++; $display("FAIL midrst_ct got %h want 0", ct[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_output got %b want 0", seen); end
        start_job(0, 64'h0011223344556677, 64'h8899AABBCCDDEEFF, 1'b1, 1'b1);
        wait_done(0, 30, lat);
        n_vec++; if (lat !== int'(NR0)) begin n_bad++; $display("FAIL midrst_next_latency got %0d want %0d", lat, NR0); end
        e = pop_exp();
        n_vec++; if (ct[0] !== e) begin n_bad++; $display("FAIL midrst_next_ct got %h want %h", ct[0], e); end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        test_reset();
        test_golden();
        test_key_rotation();
        test_backpressure();
        test_back_to_back();
        test_rounds1();
        test_rounds15();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
